bp_be_fma_sched: RTL and testbench

Issue scheduler and result-bus arbiter for the shared FP/IMUL multiply-add pipe in the BE calculator. It arbitrates between an integer-multiply requester and an FMA requester and grants at most one issue per cycle. A writeback-slot reservation vector guarantees that the two fixed-latency result streams never collide on the shared result bus. It also tracks in-flight ops, applies flush poisoning, and holds off rounding-mode (frm) CSR writes until no FMA op is in flight.

---
 rtl/bp_be_fma_sched_if.sv | 27 ++
 rtl/bp_be_fma_sched.sv | 91 +++++++++
 tb/tb_bp_be_fma_sched.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_fma_sched_if.sv
// Issue/writeback handshake bundle between the BE calculator and the
// shared FP/IMUL multiply-add scheduler.
interface bp_be_fma_sched_if;
  logic imul_req_i;
  logic fma_req_i;
  logic flush_i;
  logic frm_w_req_i;
  logic imul_gnt_o;
  logic fma_gnt_o;
  logic frm_w_gnt_o;
  logic wb_v_o;
  logic wb_is_fma_o;
  logic wb_kill_o;
  logic idle_o;

  modport master (
    output imul_req_i, fma_req_i, flush_i, frm_w_req_i,
    input  imul_gnt_o, fma_gnt_o, frm_w_gnt_o,
    input  wb_v_o, wb_is_fma_o, wb_kill_o, idle_o
  );

  modport slave (
    input  imul_req_i, fma_req_i, flush_i, frm_w_req_i,
    output imul_gnt_o, fma_gnt_o, frm_w_gnt_o,
    output wb_v_o, wb_is_fma_o, wb_kill_o, idle_o
  );
endinterface

// File: rtl/bp_be_fma_sched.sv
// Issue scheduler and result-bus arbiter for the shared multiply-add pipe.
// Slot k of each vector describes the bus k cycles from now.
module bp_be_fma_sched #(
  parameter int imul_latency_p = 4,
  parameter int fma_latency_p  = 5
) (
  input logic clk_i,
  input logic reset_n_i,
  bp_be_fma_sched_if.slave io
);
  localparam int slots_lp =
    ((imul_latency_p > fma_latency_p) ?
      imul_latency_p : fma_latency_p) + 1;

  logic [slots_lp-1:0] r_occ;
  logic [slots_lp-1:0] r_fma;
  logic [slots_lp-1:0] r_poison;
  logic                r_rr_last;

  logic [slots_lp-1:0] w_occ_n;
  logic [slots_lp-1:0] w_fma_n;
  logic [slots_lp-1:0] w_poison_n;
  logic                w_rr_last_n;

  logic w_imul_ok;
  logic w_fma_ok;
  logic w_imul_gnt;
  logic w_fma_gnt;
  logic w_fma_inflight;

  always_comb begin
    w_imul_ok = io.imul_req_i
              & ~r_occ[imul_latency_p]
              & ~io.flush_i;
    w_fma_ok  = io.fma_req_i
              & ~r_occ[fma_latency_p]
              & ~io.flush_i
              & ~io.frm_w_req_i;
    // On a tie the requester that did not win last time goes first
    w_imul_gnt = reset_n_i & w_imul_ok
               & (~w_fma_ok | ~r_rr_last);
    w_fma_gnt  = reset_n_i & w_fma_ok
               & (~w_imul_ok | r_rr_last);
    w_fma_inflight = |(r_occ & r_fma);
  end

  always_comb begin
    w_occ_n     = r_occ >> 1;
    w_fma_n     = r_fma >> 1;
    w_poison_n  = io.flush_i ?
                  ((r_occ | r_poison) >> 1) :
                  (r_poison >> 1);
    w_rr_last_n = r_rr_last;
    if (w_imul_gnt) begin
      w_occ_n[imul_latency_p-1]    = 1'b1;
      w_fma_n[imul_latency_p-1]    = 1'b0;
      w_poison_n[imul_latency_p-1] = 1'b0;
      w_rr_last_n                  = 1'b1;
    end
    if (w_fma_gnt) begin
      w_occ_n[fma_latency_p-1]    = 1'b1;
      w_fma_n[fma_latency_p-1]    = 1'b1;
      w_poison_n[fma_latency_p-1] = 1'b0;
      w_rr_last_n                 = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_occ     <= '0;
      r_fma     <= '0;
      r_poison  <= '0;
      r_rr_last <= 1'b1;
    end else begin
      r_occ     <= w_occ_n;
      r_fma     <= w_fma_n;
      r_poison  <= w_poison_n;
      r_rr_last <= w_rr_last_n;
    end
  end

  assign io.imul_gnt_o  = w_imul_gnt;
  assign io.fma_gnt_o   = w_fma_gnt;
  assign io.frm_w_gnt_o = reset_n_i
                        & io.frm_w_req_i
                        & ~w_fma_inflight;
  assign io.wb_v_o      = reset_n_i & r_occ[0] & ~r_poison[0];
  assign io.wb_kill_o   = reset_n_i & r_occ[0] & r_poison[0];
  assign io.wb_is_fma_o = reset_n_i & r_fma[0];
  assign io.idle_o      = ~reset_n_i | ~|r_occ;
endmodule

// File: tb/tb_bp_be_fma_sched.sv
// Directed and model-checked stimulus for bp_be_fma_sched
// with imul latency 4 and FMA latency 5.
module tb_bp_be_fma_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bp_be_fma_sched_if sif ();

  bp_be_fma_sched #(
    .imul_latency_p(4),
    .fma_latency_p (5)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .io       (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic got,
                     input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  task automatic drv(input logic im, input logic fm,
                     input logic fl, input logic fr);
    sif.imul_req_i  = im;
    sif.fma_req_i   = fm;
    sif.flush_i     = fl;
    sif.frm_w_req_i = fr;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0);
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  bit mb [0:127];
  bit mf [0:127];
  bit mk [0:127];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0);
    nxt();

    // Outputs forced quiet while reset is held, even with requests up
    drv(1'b1, 1'b1, 1'b0, 1'b1);
    #4;
    chk("rst_ig, ", sif.imul_gnt_o, 1'b0);
    chk("rst_fg", sif.fma_gnt_o, 1'b0);
    chk("rst_frm", sif.frm_w_gnt_o, 1'b0);
    chk("rst_wbv", sif.wb_v_o, 1'b0);
    chk("rst_kill", sif.wb_kill_o, 1'b0);
    chk("rst_isf", sif.wb_is_fma_o, 1'b0);
    chk("rst_idle", sif.idle_o, 1'b1);
    nxt();
    do_reset();

    // Single imul: grant at 0, result at 4, idle again at 5
    for (int t = 0; t < 8; t++) begin
      drv(t == 0, 1'b0, 1'b0, 1'b0);
      #4;
      chk($sformatf("t1_ig@%0d", t), sif.imul_gnt_o, t == 0);
      chk($sformatf("t1_wbv@%0d", t), sif.wb_v_o, t == 4);
      chk($sformatf("t1_idle@%0d", t), sif.idle_o,
          (t == 0) || (t >= 5));
      if (t == 4) chk("t1_isf", sif.wb_is_fma_o, 1'b0);
      nxt();
    end
    do_reset();

    // Tie at 0 goes to FMA; imul blocked at 1 by slot collision
    for (int t = 0; t < 9; t++) begin
      drv(t <= 2, t == 0, 1'b0, 1'b0);
      #4;
      chk($sformatf("t2_fg@%0d", t), sif.fma_gnt_o, t == 0);
      chk($sformatf("t2_ig@%0d", t), sif.imul_gnt_o, t == 2);
      chk($sformatf("t2_wbv@%0d", t), sif.wb_v_o,
          (t == 5) || (t == 6));
      chk($sformatf("t2_isf@%0d", t), sif.wb_is_fma_o, t == 5);
      nxt();
    end
    do_reset();

    // Round-robin: after an FMA win the next tie goes to imul
    for (int t = 0; t < 14; t++) begin
      drv((t == 6) || (t == 7),
          (t == 0) || (t == 6) || (t == 7), 1'b0, 1'b0);
      #4;
      chk($sformatf("t3_fg@%0d", t), sif.fma_gnt_o,
          (t == 0) || (t == 7));
      chk($sformatf("t3_ig@%0d", t), sif.imul_gnt_o, t == 6);
      chk($sformatf("t3_wbv@%0d", t), sif.wb_v_o,
          (t == 5) || (t == 10) || (t == 12));
      chk($sformatf("t3_isf@%0d", t), sif.wb_is_fma_o,
          (t == 5) || (t == 12));
      nxt();
    end
    do_reset();

    // Flush at 2 kills the op from 0; op granted at 3 survives
    for (int t = 0; t < 10; t++) begin
      drv(1'b0, (t == 0) || (t == 2) || (t == 3), t == 2, 1'b0);
      #4;
      chk($sformatf("t4_fg@%0d", t), sif.fma_gnt_o,
          (t == 0) || (t == 3));
      chk($sformatf("t4_wbv@%0d", t), sif.wb_v_o, t == 8);
      chk($sformatf("t4_kill@%0d", t), sif.wb_kill_o, t == 5);
      chk($sformatf("t4_idle@%0d", t), sif.idle_o,
          (t == 0) || (t == 9));
      nxt();
    end
    do_reset();

    // frm write waits for FMA slots to drain and blocks new FMA issue
    for (int t = 0; t < 10; t++) begin
      drv(1'b0, t <= 8, 1'b0, (t >= 2) && (t <= 7));
      #4;
      chk($sformatf("t5_fg@%0d", t), sif.fma_gnt_o,
          (t <= 1) || (t == 8));
      chk($sformatf("t5_frm@%0d", t), sif.frm_w_gnt_o, t == 7);
      chk($sformatf("t5_wbv@%0d", t), sif.wb_v_o,
          (t == 5) || (t == 6));
      nxt();
    end
    do_reset();

    // Reset in mid-flight discards all scheduled results
    for (int t = 0; t < 10; t++) begin
      rst_n = (t != 3);
      drv((t == 0) || (t == 3), (t == 1) || (t == 2),
          1'b0, 1'b0);
      #4;
      chk($sformatf("t6_ig@%0d", t), sif.imul_gnt_o, t == 0);
      chk($sformatf("t6_fg@%0d", t), sif.fma_gnt_o,
          (t == 1) || (t == 2));
      chk($sformatf("t6_wbv@%0d", t), sif.wb_v_o, 1'b0);
      chk($sformatf("t6_kill@%0d", t), sif.wb_kill_o, 1'b0);
      chk($sformatf("t6_idle@%0d", t), sif.idle_o,
          (t == 0) || (t >= 3));
      nxt();
    end
    do_reset();

    // Random traffic against a bus-calendar model
    begin
      bit rr;
      bit frm_p;
      bit im, fm, fl, iok, fok, ig, fg, frg, busy, fin;
      rr = 1'b1;
      frm_p = 1'b0;
      for (int j = 0; j < 128; j++) begin
        mb[j] = 1'b0;
        mf[j] = 1'b0;
        mk[j] = 1'b0;
      end
      for (int c = 0; c < 60; c++) begin
        im = ($urandom_range(0, 9) < 6);
        fm = ($urandom_range(0, 9) < 7);
        fl = ($urandom_range(0, 15) == 0);
        if (!frm_p) frm_p = ($urandom_range(0, 11) == 0);
        drv(im, fm, fl, frm_p);
        iok = im && !mb[c+4] && !fl;
        fok = fm && !mb[c+5] && !fl && !frm_p;
        ig = iok && (!fok || !rr);
        fg = fok && (!iok || rr);
        fin = 1'b0;
        busy = 1'b0;
        for (int j = c; j <= c + 5; j++) begin
          if (mb[j] && mf[j]) fin = 1'b1;
          if (mb[j]) busy = 1'b1;
        end
        frg = frm_p && !fin;
        #4;
        chk($sformatf("rnd_ig@%0d", c), sif.imul_gnt_o, ig);
        chk($sformatf("rnd_fg@%0d", c), sif.fma_gnt_o, fg);
        chk($sformatf("rnd_frm@%0d", c), sif.frm_w_gnt_o, frg);
        chk($sformatf("rnd_wbv@%0d", c), sif.wb_v_o,
            mb[c] && !mk[c]);
        chk($sformatf("rnd_kill@%0d", c), sif.wb_kill_o,
            mb[c] && mk[c]);
        chk($sformatf("rnd_isf@%0d", c), sif.wb_is_fma_o,
            mb[c] && mf[c]);
        chk($sformatf("rnd_idle@%0d", c), sif.idle_o, !busy);
        if (fl)
          for (int j = c + 1; j <= c + 5; j++)
            mk[j] = mk[j] | mb[j];
        if (ig) begin
          mb[c+4] = 1'b1;
          mf[c+4] = 1'b0;
          mk[c+4] = 1'b0;
          rr = 1'b1;
        end
        if (fg) begin
          mb[c+5] = 1'b1;
          mf[c+5] = 1'b1;
          mk[c+5] = 1'b0;
          rr = 1'b0;
        end
        if (frg) frm_p = 1'b0;
        nxt();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
